// File: rtl/fpmul_share_ctrl.sv
// rtl/fpmul_share_ctrl.sv - round-robin sharing controller for one combinational FP32 multiplier
// Optional zero-operand shortcut: FPMUL_SHARE_ZERO_BYPASS_EN
module fpmul_share_ctrl #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 2,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_out,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  input  logic                 rsp_ready,
  output logic                 busy
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     mul_a_q, mul_b_q, rsp_data_q;
  logic [IDW-1:0]  rsp_id_q;
  logic            rsp_valid_q, busy_q;

  logic            found_d;
  logic [IDW-1:0]  grant_d, ptr_d;
  logic [31:0]     op_a_d, op_b_d;
  logic            take_d;
`ifdef FPMUL_SHARE_ZERO_BYPASS_EN
  logic            zero_d;
`endif

  // Search starts at ptr and wraps, so the most recently served requester is last in line.
  always_comb begin
    int j;
    j       = 0;
    found_d = 1'b0;
    grant_d = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found_d && req_valid[j]) begin
        found_d = 1'b1;
        grant_d = IDW'(j);
      end
    end
  end

  always_comb begin
    op_a_d = '0;
    op_b_d = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_d == IDW'(k)) begin
        op_a_d = req_a[32*k +: 32];
        op_b_d = req_b[32*k +: 32];
      end
    end
  end

  assign ptr_d  = (grant_d == IDW'(NREQ-1)) ? '0 : grant_d + 1'b1;
  assign take_d = (state_q == S_IDLE) && found_d;

`ifdef FPMUL_SHARE_ZERO_BYPASS_EN
  assign zero_d = (op_a_d[30:0] == 31'd0) || (op_b_d[30:0] == 31'd0);
`endif

  // Grant is combinational so a waiting requester transfers in its first IDLE cycle.
  always_comb begin
    req_ready = '0;
    if (take_d && !rst) req_ready[grant_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (take_d) begin
            mul_a_q  <= op_a_d;
            mul_b_q  <= op_b_d;
            rsp_id_q <= grant_d;
            ptr_q    <= ptr_d;
            cnt_q    <= CW'(SETTLE - 1);
            busy_q   <= 1'b1;
`ifdef FPMUL_SHARE_ZERO_BYPASS_EN
            if (zero_d) begin
              rsp_data_q  <= {op_a_d[31] ^ op_b_d[31], 31'd0};
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              state_q <= S_WAIT;
            end
`else
            state_q <= S_WAIT;
`endif
          end
        end
        S_WAIT: begin
          // Product is only trusted on the last settle cycle.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            rsp_data_q  <= mul_out;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fpmul_share_ctrl.sv
// tb/tb_fpmul_share_ctrl.sv - directed self-checking bench for fpmul_share_ctrl
module tb_fpmul_share_ctrl;
  localparam int NREQ   = 4;
  localparam int SETTLE = 2;
  localparam int IDW    = 2;
`ifdef FPMUL_SHARE_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = SETTLE + 1;
`endif

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic [31:0]          mul_a, mul_b, mul_out;
  logic                 rsp_valid;
  logic [31:0]          rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_ready;
  logic                 busy;

  int n_cmp = 0;
  int n_bad = 0;

  fpmul_share_ctrl #(.NREQ(NREQ), .SETTLE(SETTLE), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  // Stand-in multiplier: hand-computed products for the operand pairs used below.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3FC00000_40000000: fmul = 32'h40400000;
      64'h40000000_40000000: fmul = 32'h40800000;
      64'hC0000000_3F000000: fmul = 32'hBF800000;
      64'h40400000_3F000000: fmul = 32'h3FC00000;
      64'h00000000_C0400000: fmul = 32'h80000000;
      64'h3F800000_3F800000: fmul = 32'h3F800000;
      default:               fmul = a ^ b;
    endcase
  endfunction

  assign mul_out = fmul(mul_a, mul_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input int exp_lat);
    int n;
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
    req_valid = 4'b0001 << idx;
    #1;
    check("grant", 32'(req_ready), 32'(4'b0001 << idx));
    tick;
    req_valid = '0;
    check("mul_a", mul_a, a);
    check("mul_b", mul_b, b);
    check("busy_op", 32'(busy), 32'd1);
    n = 1;
    while (!rsp_valid && n < 20) begin
      tick;
      n++;
    end
    check("latency", 32'(n), 32'(exp_lat));
    check("rsp_data", rsp_data, exp_d);
    check("rsp_id", 32'(rsp_id), 32'(idx));
    if (rsp_ready) begin
      tick;
      check("rsp_done", 32'(rsp_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  logic [31:0] rr_a [4];
  logic [31:0] rr_b [4];
  logic [31:0] rr_p [4];

  initial begin
    int g, r, last, cnt;
    rr_a = '{32'h3FC00000, 32'h40000000, 32'hC0000000, 32'h40400000};
    rr_b = '{32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F000000};
    rr_p = '{32'h40400000, 32'h40800000, 32'hBF800000, 32'h3FC00000};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    #12;
    check("rst_mul_a", mul_a, 32'd0);
    check("rst_mul_b", mul_b, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    tick;
    rst = 1'b0;
    tick;

    run_op(0, 32'h3FC00000, 32'h40000000, 32'h40400000, SETTLE + 1);
    run_op(2, 32'hC0000000, 32'h3F000000, 32'hBF800000, SETTLE + 1);
    run_op(1, 32'h00000000, 32'hC0400000, 32'h80000000, ZLAT);

    // Round-robin with every requester valid straight out of reset
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = rr_a[i];
      req_b[32*i +: 32] = rr_b[i];
    end
    req_valid = 4'hF;
    #1;
    check("rr_rst_ready", 32'(req_ready), 32'd0);
    tick;
    rst = 1'b0;
    #1;
    g = 0; r = 0; last = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (req_ready != '0) begin
        check("rr_onehot", 32'($onehot(req_ready)), 32'd1);
        check("rr_order", 32'(req_ready), 32'(4'b0001 << (g % 4)));
        if (g > 0) check("rr_interval", 32'(cyc - last), 32'(SETTLE + 2));
        last = cyc;
        g++;
      end
      if (rsp_valid) begin
        check("rr_id", 32'(rsp_id), 32'(r % 4));
        check("rr_data", rsp_data, rr_p[r % 4]);
        r++;
      end
      if (cyc == 19) req_valid = '0;
      tick;
    end
    check("rr_grants", 32'(g), 32'd5);
    check("rr_rsps", 32'(r), 32'd5);

    // Backpressure: ptr is 1, so requester 3 is the only one asking
    rsp_ready = 1'b0;
    run_op(3, 32'h40400000, 32'h3F000000, 32'h3FC00000, SETTLE + 1);
    req_a[31:0] = 32'h40000000;
    req_b[31:0] = 32'h40000000;
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", rsp_data, 32'h3FC00000);
      check("bp_id", 32'(rsp_id), 32'd3);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick;
    check("bp_done", 32'(rsp_valid), 32'd0);
    check("bp_regrant", 32'(req_ready), 32'd1);

    // Reset in the cycle after requester 0 transfers
    tick;
    check("mw_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    req_valid = '0;
    #1;
    check("mw_mul_a", mul_a, 32'd0);
    check("mw_mul_b", mul_b, 32'd0);
    check("mw_busy0", 32'(busy), 32'd0);
    check("mw_valid", 32'(rsp_valid), 32'd0);
    check("mw_id", 32'(rsp_id), 32'd0);
    check("mw_ready", 32'(req_ready), 32'd0);
    tick;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (rsp_valid) cnt++;
    end
    check("mw_no_rsp", 32'(cnt), 32'd0);
    req_valid = 4'b1001;
    #1;
    check("mw_ptr0", 32'(req_ready), 32'd1);
    run_op(0, 32'h3F800000, 32'h3F800000, 32'h3F800000, SETTLE + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/fpmul_share_ctrl.md
# fpmul_share_ctrl

Sequential controller that shares one combinational single-precision floating-point multiplier among NREQ requesters.
- Arbitrates requests round-robin and registers the granted operand pair onto the multiplier inputs.
- Waits a fixed settle time, captures the product, and returns it on a single tagged response channel.
- Sits between the ALU issue logic and the shared multiplier datapath, so only one multiplier instance is needed.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8).
- SETTLE, 2, cycles allowed for the multiplier's combinational path to settle (≥1).
- IDW, $clog2(NREQ), response tag width (derived).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  32*NREQ  operand A for requester i, on bits [32i+31:32i].
- req_b  in  32*NREQ  operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- mul_a  out  32  registered operand A driven to the multiplier.
- mul_b  out  32  registered operand B driven to the multiplier.
- mul_out  in  32  multiplier product, combinational from mul_a and mul_b.
- rsp_valid  out  1  response valid.
- rsp_data  out  32  captured product.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- rsp_ready  in  1  response consumer ready.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
States:
- IDLE
  - grant = the first index at or after ptr, wrapping modulo NREQ, whose req_valid is 1.
  - req_ready[grant] = 1; all other req_ready bits = 0.
  - req_ready is all zero when no request is valid, and in every state other than IDLE.
  - On transfer:
    - mul_a ← req_a[grant], mul_b ← req_b[grant], rsp_id ← grant.
    - ptr ← grant+1 mod NREQ; cnt ← SETTLE-1.
    - Next state: WAIT.
- WAIT
  - mul_a and mul_b are held constant.
  - If cnt ≠ 0: cnt ← cnt-1.
  - If cnt = 0: rsp_data ← mul_out; next state RESP.
- RESP
  - rsp_valid = 1.
  - rsp_data and rsp_id are held stable until rsp_valid & rsp_ready.
  - On that transfer: next state IDLE.
- ptr changes only on a request transfer, and never while req_valid is all zero.
- Requests are never dropped or reordered. A requester that holds req_valid high is granted within NREQ operations.
- The multiplier output is sampled only in the final WAIT cycle. Glitches before that point are ignored.
- rsp_data is bit-exact with mul_out. The controller applies no rounding or normalization.

## Timing
Reset values (rst=1, asynchronous):
- State IDLE; ptr=0; cnt=0.
- mul_a=0, mul_b=0, rsp_data=0, rsp_id=0.
- rsp_valid=0, busy=0, req_ready=0.

Latency and throughput:
- A request transfer in cycle T makes rsp_valid high from cycle T+SETTLE+1.
- mul_a and mul_b are valid from cycle T+1.
- The RESP→IDLE transition costs one cycle. A new grant is possible in the cycle after the response transfer.
- Minimum issue interval is SETTLE+2 cycles.

Boundary conditions:
- Backpressure: rsp_ready low holds the block in RESP indefinitely, with all outputs frozen.
- Reset mid-operation: any state returns to IDLE immediately and the in-flight result is discarded. No response is produced.
- A requester deasserting req_valid before its grant is legal; it simply loses arbitration.
- All requesters valid simultaneously: the grant order is ptr, ptr+1, …, wrapping.

## Configuration
- FPMUL_SHARE_ZERO_BYPASS_EN defined: special-case zero operands.
  - Applies on a transfer where req_a[30:0]==0 or req_b[30:0]==0.
  - The block skips WAIT and goes straight to RESP the next cycle.
  - rsp_data = {a[31]^b[31], 31'b0}; mul_a and mul_b still load.
  - Latency for this case is 1 cycle.
- Macro undefined: every operation goes through WAIT with latency SETTLE+1.

## Test plan
- Basic: req 0 with A=0x3FC00000 and B=0x40000000 (1.5×2.0), rsp_ready=1.
  - rsp_valid asserts 3 cycles after the transfer, with rsp_data=0x40400000 and rsp_id=0.
  - busy is high throughout.
- Sign: req 2 with A=0xC0000000 and B=0x3F000000.
  - rsp_data=0xBF800000, rsp_id=2.
- Round-robin: all four req_valid held high from reset, each with distinct operands.
  - Grants occur in order 0,1,2,3,0, one-hot with no overlap.
  - Each rsp_id matches its grant, and consecutive grants are 4 cycles apart.
- Backpressure: hold rsp_ready=0 for 5 cycles during RESP.
  - rsp_valid, rsp_data and rsp_id stay stable, and req_ready stays 0.
  - The response transfers on the cycle rsp_ready rises.
- Reset mid-WAIT: assert rst in the cycle after the transfer.
  - All outputs return to their reset values immediately and no response appears.
  - The next request after reset is granted starting from index 0.
- Zero (with FPMUL_SHARE_ZERO_BYPASS_EN): A=0x00000000, B=0xC0400000.
  - rsp_data=0x80000000 one cycle after the transfer.
  - Without the macro, the same response arrives after SETTLE+1 cycles with rsp_data equal to mul_out.
